// File: rtl/colparity_controller.sv
// Column-parity sequencer: loads each file, primes with slice NUM_LINES-1, sweeps slices
// 0..NUM_LINES-1 into the datapath and emits a CP_LATENCY-delayed write strobe per slice.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_LOAD  | one-cycle reader load pulse for file_index
// S_PRIME | present slice NUM_LINES-1 as wrap-around neighbour only
// S_RUN   | issue slices 0..NUM_LINES-1, one per cycle
// S_DRAIN | CP_LATENCY cycles for the last results to be written
// S_NEXT  | advance file, decide reload or finish
// S_DONE  | one-cycle completion pulse
module colparity_controller #(
  parameter int NUM_LINES  = 64,
  parameter int LINE_W     = 6,
  parameter int FILE_W     = 10,
  parameter int CP_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FILE_W-1:0] first_file,
  input  logic [FILE_W-1:0] num_files,
  output logic              read_file,
  output logic [FILE_W-1:0] file_index,
  output logic [LINE_W-1:0] line_index,
  output logic              cp_prime,
  output logic              cp_valid,
  output logic              cp_first,
  output logic              cp_last,
  output logic              wr_en,
  output logic [LINE_W-1:0] wr_line_index,
  output logic              busy,
  output logic              done
);

  localparam int DRAIN_W = (CP_LATENCY > 1) ? $clog2(CP_LATENCY) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(CP_LATENCY - 1);
  localparam logic [LINE_W-1:0]  LAST_LINE  = LINE_W'(NUM_LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PRIME, S_RUN, S_DRAIN, S_NEXT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [FILE_W-1:0]  files_left;
  logic [LINE_W-1:0]  line_cnt;
  logic [DRAIN_W-1:0] drain_cnt;

  logic [CP_LATENCY-1:0] pipe_v;
  logic [LINE_W-1:0]     pipe_idx [CP_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (num_files == '0) ? S_DONE : S_LOAD;
      S_LOAD:  state_nxt = S_PRIME;
      S_PRIME: state_nxt = S_RUN;
      S_RUN:   if (line_cnt == LAST_LINE) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt == '0) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = (files_left == FILE_W'(1)) ? S_DONE : S_LOAD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    read_file  = 1'b0;
    line_index = '0;
    cp_prime   = 1'b0;
    cp_valid   = 1'b0;
    cp_first   = 1'b0;
    cp_last    = 1'b0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_LOAD:  read_file = 1'b1;
      S_PRIME: begin
        line_index = LAST_LINE;
        cp_prime   = 1'b1;
      end
      S_RUN: begin
        line_index = line_cnt;
        cp_valid   = 1'b1;
        cp_first   = (line_cnt == '0);
        cp_last    = (line_cnt == LAST_LINE);
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Drain timer is preloaded on every RUN cycle so it is ready when DRAIN starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      file_index <= '0;
      files_left <= '0;
      line_cnt   <= '0;
      drain_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          file_index <= first_file;
          files_left <= num_files;
        end
        S_PRIME: line_cnt <= '0;
        S_RUN: begin
          line_cnt  <= line_cnt + 1'b1;
          drain_cnt <= DRAIN_INIT;
        end
        S_DRAIN: if (drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
        S_NEXT: begin
          files_left <= files_left - 1'b1;
          file_index <= file_index + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Index is zeroed when not valid so wr_line_index never shows the priming slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i < CP_LATENCY; i++) pipe_idx[i] <= '0;
    end else begin
      pipe_v[0]   <= cp_valid;
      pipe_idx[0] <= cp_valid ? line_index : '0;
      for (int i = 1; i < CP_LATENCY; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  assign wr_en         = pipe_v[CP_LATENCY-1];
  assign wr_line_index = pipe_idx[CP_LATENCY-1];

endmodule

// File: tb/tb_colparity_controller.sv
// Bench for colparity_controller: latency-1 and latency-3 instances share stimulus and are
// compared every cycle against a per-run arithmetic timeline model.
module tb_colparity_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] first_file = '0;
  logic [9:0] num_files = '0;

  logic       rf0, pr0, va0, fi0, la0, we0, bu0, dn0;
  logic [9:0] fx0;
  logic [5:0] li0, wi0;
  logic       rf1, pr1, va1, fi1, la1, we1, bu1, dn1;
  logic [9:0] fx1;
  logic [5:0] li1, wi1;

  always #5 clk = ~clk;

  colparity_controller #(.CP_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .start(start), .first_file(first_file), .num_files(num_files),
    .read_file(rf0), .file_index(fx0), .line_index(li0), .cp_prime(pr0), .cp_valid(va0),
    .cp_first(fi0), .cp_last(la0), .wr_en(we0), .wr_line_index(wi0), .busy(bu0), .done(dn0)
  );

  colparity_controller #(.CP_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .start(start), .first_file(first_file), .num_files(num_files),
    .read_file(rf1), .file_index(fx1), .line_index(li1), .cp_prime(pr1), .cp_valid(va1),
    .cp_first(fi1), .cp_last(la1), .wr_en(we1), .wr_line_index(wi1), .busy(bu1), .done(dn1)
  );

  logic [29:0] obs [2];
  assign obs[0] = {rf0, pr0, va0, fi0, la0, we0, bu0, dn0, fx0, li0, wi0};
  assign obs[1] = {rf1, pr1, va1, fi1, la1, we1, bu1, dn1, fx1, li1, wi1};

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: an active run is a position k (cycles since the accepting edge).
  int lat    [2] = '{1, 3};
  int act    [2] = '{0, 0};
  int k      [2] = '{0, 0};
  int mfirst [2] = '{0, 0};
  int mnum   [2] = '{0, 0};
  int fidx   [2] = '{0, 0};

  function automatic logic [29:0] exp_vec(input int i);
    int per, dk, j, f, p, line, widx;
    logic rd, prm, vld, fst, lst, wr, bsy, dne;
    logic [9:0] fx;
    rd = 0; prm = 0; vld = 0; fst = 0; lst = 0; wr = 0; bsy = 0; dne = 0;
    line = 0; widx = 0;
    fx = 10'(fidx[i]);
    if (act[i] != 0) begin
      per = 67 + lat[i];
      dk  = mnum[i] * per + 1;
      bsy = 1;
      if (k[i] == dk) begin
        dne = 1;
        fx  = 10'((mfirst[i] + mnum[i]) % 1024);
      end else begin
        j = k[i] - 1;
        f = j / per;
        p = j % per;
        fx  = 10'((mfirst[i] + f) % 1024);
        rd  = (p == 0);
        prm = (p == 1);
        vld = (p >= 2 && p <= 65);
        if (prm) line = 63;
        if (vld) line = p - 2;
        fst = vld && (p == 2);
        lst = vld && (p == 65);
        wr  = (p >= 2 + lat[i] && p <= 65 + lat[i]);
        if (wr) widx = p - 2 - lat[i];
      end
    end
    return {rd, prm, vld, fst, lst, wr, bsy, dne, fx, 6'(line), 6'(widx)};
  endfunction

  task automatic model_edge(input logic s, input logic [9:0] ff, input logic [9:0] nf,
                            input logic r);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        act[i]  = 0;
        fidx[i] = 0;
      end else if (act[i] != 0) begin
        k[i]++;
        if (k[i] > mnum[i] * (67 + lat[i]) + 1) begin
          act[i]  = 0;
          fidx[i] = (mfirst[i] + mnum[i]) % 1024;
        end
      end else if (s) begin
        act[i]    = 1;
        k[i]      = 1;
        mfirst[i] = int'(ff);
        mnum[i]   = int'(nf);
      end
    end
  endtask

  task automatic check(input int i);
    logic [29:0] e;
    e = exp_vec(i);
    n_vec++;
    assert (obs[i] === e) else begin
      n_err++;
      $error("FAIL lat%0d cyc %0d outputs: got %h expected %h", lat[i], cyc, obs[i], e);
    end
  endtask

  task automatic step(input logic s, input logic [9:0] ff, input logic [9:0] nf,
                      input logic r);
    start = s; first_file = ff; num_files = nf; rst = r;
    @(posedge clk);
    cyc++;
    model_edge(s, ff, nf, r);
    @(negedge clk);
    check(0);
    check(1);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b0, 10'd0, 10'd0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    for (int c = 0; c < 3; c++) step(1'b0, 10'd0, 10'd0, 1'b1);

    // single file starting at 5
    step(1'b1, 10'd5, 10'd1, 1'b0);
    idle(75);

    // three files wrapping the file index; a start during RUN slice 10 is ignored
    step(1'b1, 10'd1022, 10'd3, 1'b0);
    idle(12);
    step(1'b1, 10'd7, 10'd2, 1'b0);
    idle(215);

    // zero files, then a start in the DONE cycle which must be ignored
    step(1'b1, 10'd9, 10'd0, 1'b0);
    step(1'b1, 10'd4, 10'd1, 1'b0);
    idle(3);

    // reset during RUN slice 30, then a clean file
    step(1'b1, 10'd20, 10'd1, 1'b0);
    idle(32);
    step(1'b0, 10'd0, 10'd0, 1'b1);
    idle(5);
    step(1'b1, 10'd21, 10'd1, 1'b0);
    idle(75);

    // random starts, run lengths and occasional resets
    for (int n = 0; n < 800; n++)
      step(1'($urandom_range(0, 19) == 0), 10'($urandom_range(0, 1023)),
           10'($urandom_range(0, 2)), 1'($urandom_range(0, 499) == 0));
    idle(250);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
